// File: rtl/cpu6_memarb.sv
// Shares one memory bus between fetch and load/store. Data wins by default, but a starvation guard lets fetch through.
// mem_req rises one cycle after the grant. The valid pulse comes with mem_ack. The next arbitration is in the following IDLE cycle.
module cpu6_memarb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_valid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       kill_pend;
  logic       starved;
  logic       grant_d;
  logic       grant_i;

  // Fetch has waited long enough, so it takes precedence over data this time.
  assign starved = if_req && (starve_cnt == STARVE_LIM);
  assign grant_d = ls_req && !starved;
  assign grant_i = !grant_d && if_req && !if_kill;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      kill_pend  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!if_req) begin
            starve_cnt <= 4'd0;
          end else if (grant_d && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
          end else if (grant_i) begin
            state      <= BUSY_I;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            starve_cnt <= 4'd0;
            kill_pend  <= 1'b0;
          end
        end
        BUSY_I: begin
          // The bus cycle cannot be aborted; a kill only hides its result.
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            kill_pend <= 1'b0;
          end else if (if_kill) begin
            kill_pend <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_valid = (state == BUSY_I) && mem_ack && !kill_pend && !if_kill;
  assign ls_valid = (state == BUSY_D) && mem_ack;
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign ls_rdata = ls_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_cpu6_memarb.sv
// Bench for cpu6_memarb: a vector table of single transactions plus hand sequences; a scoreboard checks each valid pulse.
module tb_cpu6_memarb;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_valid, ls_valid, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        mem_ack, mem_ack_drv, ack_tie;
  logic [31:0] mem_rdata, mem_rdata_drv;

  localparam logic [31:0] TIE_MASK = 32'hA5A5_0000;

  // In tie mode the bus acks immediately and returns addr ^ mask.
  assign mem_ack   = ack_tie ? mem_req : mem_ack_drv;
  assign mem_rdata = ack_tie ? (mem_addr ^ TIE_MASK) : mem_rdata_drv;

  always #5 clk = ~clk;

  cpu6_memarb #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        is_fetch;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        if_req, if_kill, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    int          lat;
    logic [31:0] rdata;
    int          grant;     // 0 none, 1 fetch, 2 data
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;
  vec_t vecs[8];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_valid) begin
      if (sb.size() == 0) check("unexpected if_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("if_valid owner", {31'd0, e.is_fetch}, 32'd1);
        check("if_rdata", if_rdata, e.rdata);
      end
    end else check("if_rdata zero when idle", if_rdata, 32'd0);
    if (ls_valid) begin
      if (sb.size() == 0) check("unexpected ls_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("ls_valid owner", {31'd0, e.is_fetch}, 32'd0);
        check("ls_rdata", ls_rdata, e.rdata);
      end
    end else check("ls_rdata zero when idle", ls_rdata, 32'd0);
  end

  // Called in the first BUSY cycle: wait lat cycles, then ack for one cycle.
  task automatic run_txn(input logic is_fetch, input int lat, input logic [31:0] rdata,
                         input logic [31:0] addr, input logic push);
    exp_t e;
    for (int i = 0; i < lat; i++) begin
      check("mem_req held", {31'd0, mem_req}, 32'd1);
      check("mem_addr stable", mem_addr, addr);
      step();
    end
    mem_ack_drv   = 1'b1;
    mem_rdata_drv = rdata;
    e.is_fetch = is_fetch;
    e.rdata    = rdata;
    if (push) sb.push_back(e);
    step();
    mem_ack_drv = 1'b0;
    check("mem_req low after ack", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic clear_reqs();
    if_req = 0; if_kill = 0; ls_req = 0; ls_we = 0;
  endtask

  initial begin
    exp_t e;
    logic [31:0] a;
    logic        f;
    reset = 1; ack_tie = 0; mem_ack_drv = 0; mem_rdata_drv = 32'h0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    clear_reqs();

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 2, 32'hDEADBEEF, 1, 1'b0, 32'h100, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h204, 32'h0, 0, 32'h0BAD_F00D, 2, 1'b0, 32'h204, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h208, 32'h12345678, 3, 32'h0, 2, 1'b1, 32'h208, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10C, 32'h20C, 32'h0, 1, 32'h13572468, 2, 1'b0, 32'h20C, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h110, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h114, 32'h210, 32'hAA, 1, 32'h5A5A5A5A, 2, 1'b1, 32'h210, 32'hAA};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h118, 32'h0, 32'h0, 0, 32'h87654321, 1, 1'b0, 32'h118, 32'h0};

    step(); step();
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset if_valid", {31'd0, if_valid}, 32'd0);
    check("reset ls_valid", {31'd0, ls_valid}, 32'd0);
    reset = 0;
    step();

    for (int v = 0; v < 8; v++) begin
      if_req = vecs[v].if_req; if_kill = vecs[v].if_kill; if_addr = vecs[v].if_addr;
      ls_req = vecs[v].ls_req; ls_we = vecs[v].ls_we;
      ls_addr = vecs[v].ls_addr; ls_wdata = vecs[v].ls_wdata;
      step();
      check($sformatf("vec%0d mem_req", v), {31'd0, mem_req}, {31'd0, vecs[v].grant != 0});
      if (vecs[v].grant != 0) begin
        check($sformatf("vec%0d mem_we", v), {31'd0, mem_we}, {31'd0, vecs[v].exp_we});
        check($sformatf("vec%0d mem_addr", v), mem_addr, vecs[v].exp_addr);
        if (vecs[v].grant == 2)
          check($sformatf("vec%0d mem_wdata", v), mem_wdata, vecs[v].exp_wdata);
        run_txn(vecs[v].grant == 1, vecs[v].lat, vecs[v].rdata, vecs[v].exp_addr, 1'b1);
      end
      clear_reqs();
      step();
      check($sformatf("vec%0d idle after", v), {31'd0, mem_req}, 32'd0);
    end

    // Collision: the store goes first and the fetch follows in the next IDLE cycle.
    if_req = 1; if_addr = 32'h300; ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h55;
    step();
    check("collision mem_we", {31'd0, mem_we}, 32'd1);
    check("collision mem_addr", mem_addr, 32'h200);
    check("collision mem_wdata", mem_wdata, 32'h55);
    run_txn(1'b0, 0, 32'hCAFE, 32'h200, 1'b1);
    ls_req = 0; ls_we = 0;
    step();
    check("collision fetch mem_req", {31'd0, mem_req}, 32'd1);
    check("collision fetch addr", mem_addr, 32'h300);
    check("collision fetch we", {31'd0, mem_we}, 32'd0);
    run_txn(1'b1, 1, 32'hF00D, 32'h300, 1'b1);
    clear_reqs();
    step();

    // Kill before the ack: the bus cycle completes but no if_valid; the next fetch is normal.
    if_req = 1; if_addr = 32'h700;
    step();
    check("kill fetch addr", mem_addr, 32'h700);
    if_kill = 1;
    step();
    if_kill = 0;
    step();
    mem_ack_drv = 1; mem_rdata_drv = 32'h1111;
    #1;
    check("kill suppresses if_valid", {31'd0, if_valid}, 32'd0);
    check("kill mem_req still high", {31'd0, mem_req}, 32'd1);
    step();
    mem_ack_drv = 0; if_addr = 32'h80;
    step();
    check("post-kill fetch addr", mem_addr, 32'h80);
    run_txn(1'b1, 1, 32'h2222, 32'h80, 1'b1);
    clear_reqs();
    step();

    // Kill in the same cycle as the ack.
    if_req = 1; if_addr = 32'h90;
    step();
    mem_ack_drv = 1; mem_rdata_drv = 32'h3333; if_kill = 1;
    #1;
    check("same-cycle kill", {31'd0, if_valid}, 32'd0);
    step();
    mem_ack_drv = 0;
    clear_reqs();
    step();

    // Starvation: four data grants, then a fetch, then four data grants again.
    ack_tie = 1;
    for (int g = 0; g < 10; g++) begin
      ls_req = 1; ls_we = 0; ls_addr = 32'h600 + 32'(4 * g);
      if_req = 1; if_addr = 32'h500 + 32'(16 * (g / 5));
      f = (g % 5) == 4;
      a = f ? if_addr : ls_addr;
      e.is_fetch = f; e.rdata = a ^ TIE_MASK;
      sb.push_back(e);
      step();
      check($sformatf("starve grant%0d addr", g), mem_addr, a);
      step();
    end
    clear_reqs();
    step();

    // Zero-latency bus with alternating requesters: one transaction every two cycles.
    for (int k = 0; k < 6; k++) begin
      f = (k % 2) == 1;
      if_req = f; ls_req = !f; ls_we = (k % 4) == 2;
      if_addr = 32'h400 + 32'(4 * k); ls_addr = 32'h300 + 32'(4 * k); ls_wdata = 32'(k);
      a = f ? if_addr : ls_addr;
      e.is_fetch = f; e.rdata = a ^ TIE_MASK;
      sb.push_back(e);
      step();
      check($sformatf("zl%0d if_valid", k), {31'd0, if_valid}, {31'd0, f});
      check($sformatf("zl%0d ls_valid", k), {31'd0, ls_valid}, {31'd0, !f});
      check($sformatf("zl%0d mem_addr", k), mem_addr, a);
      step();
    end
    clear_reqs();
    ack_tie = 0;
    step();

    // Reset in the middle of a store; a late ack must be ignored.
    ls_req = 1; ls_we = 1; ls_addr = 32'h800; ls_wdata = 32'h77;
    step();
    check("midop mem_req", {31'd0, mem_req}, 32'd1);
    step();
    reset = 1;
    step();
    check("midop reset mem_req", {31'd0, mem_req}, 32'd0);
    check("midop reset mem_we", {31'd0, mem_we}, 32'd0);
    check("midop reset mem_addr", mem_addr, 32'd0);
    check("midop reset mem_wdata", mem_wdata, 32'd0);
    reset = 0; clear_reqs();
    mem_ack_drv = 1; mem_rdata_drv = 32'h9999;
    #1;
    check("late ack ls_valid", {31'd0, ls_valid}, 32'd0);
    check("late ack if_valid", {31'd0, if_valid}, 32'd0);
    step();
    mem_ack_drv = 0;
    step();
    step();

    check("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
